// File: rtl/ram_16x256.sv
// Simple dual-port synchronous RAM, one write and one registered read port on one clock.
// Used as the FIR sample delay line; same-address read-during-write returns the old word.
module ram_16x256 #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] wraddress,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] rdaddress,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Power-up contents come from the device configuration image.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    // NOTE: the array sits in a clock-only process with no reset branch; a reset
    // on the storage would prevent mapping to a block RAM.
    always_ff @(posedge clock) begin
        if (wren && reset_n) begin
            mem[wraddress] <= data;
        end
    end

    // NOTE: non-blocking assignments make the read sample the pre-write word,
    // giving old-data behaviour on a same-address read-during-write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else begin
            q <= mem[rdaddress];
        end
    end

endmodule

// File: tb/tb_ram_16x256.sv
// Self-checking bench for ram_16x256: directed scenarios plus random traffic,
// checked against an array-based reference of the read-before-write rule.
module tb_ram_16x256;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] data;
    logic [7:0]  wraddress;
    logic        wren;
    logic [7:0]  rdaddress;
    logic [15:0] q;

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_mem [256];

    ram_16x256 dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .data      (data),
        .wraddress (wraddress),
        .wren      (wren),
        .rdaddress (rdaddress),
        .q         (q)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clock: drive inputs, predict q from the model, advance, compare.
    task automatic cycle(input logic we, input logic [7:0] wa, input logic [15:0] d,
                         input logic [7:0] ra, input string tag);
        logic [15:0] exp_q;
        wren      = we;
        wraddress = wa;
        data      = d;
        rdaddress = ra;
        exp_q = reset_n ? ref_mem[ra] : 16'h0000;
        if (we && reset_n) ref_mem[wa] = d;
        @(posedge clock);
        #1;
        check(tag, q, exp_q);
    endtask

    initial begin
        logic [7:0] last_wa;
        logic [7:0] wa;
        logic [7:0] ra;

        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
        reset_n   = 1'b0;
        wren      = 1'b0;
        data      = 16'h0000;
        wraddress = 8'h00;
        rdaddress = 8'h00;

        // Power-up / reset
        #3;
        check("reset_q", q, 16'h0000);
        cycle(1'b1, 8'h00, 16'h7777, 8'h00, "reset_write_ignored");
        cycle(1'b0, 8'h00, 16'h0000, 8'h00, "reset_hold");
        reset_n = 1'b1;
        cycle(1'b0, 8'h00, 16'h0000, 8'h00, "init_read_00");
        check("init_read_00_const", q, 16'h0000);

        // Write / read back
        cycle(1'b1, 8'h05, 16'h1234, 8'h00, "wr_05");
        cycle(1'b1, 8'hFF, 16'hFFFF, 8'h05, "rd_05");
        check("rd_05_const", q, 16'h1234);
        cycle(1'b1, 8'h00, 16'h8000, 8'hFF, "rd_ff");
        check("rd_ff_const", q, 16'hFFFF);
        cycle(1'b0, 8'h00, 16'h0000, 8'h00, "rd_00");
        check("rd_00_const", q, 16'h8000);

        // Read-during-write, same address
        cycle(1'b1, 8'h10, 16'hAAAA, 8'h00, "rdw_setup");
        cycle(1'b1, 8'h10, 16'h5555, 8'h10, "rdw_old");
        check("rdw_old_const", q, 16'hAAAA);
        cycle(1'b0, 8'h00, 16'h0000, 8'h10, "rdw_new");
        check("rdw_new_const", q, 16'h5555);

        // wren gating
        cycle(1'b0, 8'h20, 16'hDEAD, 8'h00, "gate_nowrite");
        cycle(1'b0, 8'h00, 16'h0000, 8'h20, "gate_read_20");
        check("gate_read_20_const", q, 16'h0000);

        // Reset mid-operation
        cycle(1'b1, 8'h30, 16'h0BEE, 8'h00, "rst_setup");
        cycle(1'b0, 8'h00, 16'h0000, 8'h30, "rst_pre");
        check("rst_pre_const", q, 16'h0BEE);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_drop", q, 16'h0000);
        #1;
        cycle(1'b1, 8'h30, 16'h1111, 8'h30, "rst_write_ignored");
        reset_n = 1'b1;
        cycle(1'b0, 8'h00, 16'h0000, 8'h30, "rst_contents_kept");
        check("rst_contents_kept_const", q, 16'h0BEE);

        // Random traffic with frequent same-address collisions
        for (int i = 0; i < 300; i++) begin
            wa = 8'($urandom_range(0, 255));
            ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 255));
            cycle(1'($urandom), wa, 16'($urandom), ra, "random");
        end

        // Streaming delay line: ramp 0..299 with wrapping write address
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 8'(i), 16'(i), 8'($urandom_range(0, 255)), "stream_wr");
        end
        last_wa = 8'(299);
        for (int k = 0; k <= 190; k++) begin
            cycle(1'b0, 8'h00, 16'h0000, 8'(last_wa - 8'd190 + 8'(k)), "stream_rd");
            check("stream_rd_ramp", q, 16'(109 + k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
